// File: rtl/ones_counter_15.sv
// Registered 15-input population counter built from a full-adder tree, with an optional input register stage.
// Optional none_set/all_set flag outputs are enabled by defining ONES_COUNTER_FLAGS_EN.
module ones_counter_15 #(
  parameter int unsigned REG_INPUT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] in_vec,
  input  logic        in_valid,
  output logic        cnt3,
  output logic        cnt2,
  output logic        cnt1,
  output logic        cnt0,
  output logic        out_valid
`ifdef ONES_COUNTER_FLAGS_EN
  ,
  output logic        none_set,
  output logic        all_set
`endif
);

  // Returns {carry, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  logic [14:0] tree_vec;
  logic        tree_valid;

  if (REG_INPUT != 0) begin : g_in_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        tree_vec   <= '0;
        tree_valid <= 1'b0;
      end else begin
        tree_vec   <= in_vec;
        tree_valid <= in_valid;
      end
    end
  end else begin : g_no_in_reg
    assign tree_vec   = in_vec;
    assign tree_valid = in_valid;
  end

  // Weight-1 column: five FAs on the raw bits produce five sums (weight 1) and five carries (weight 2).
  logic [4:0] w1_sum;
  logic [4:0] w2_bit;
  for (genvar i = 0; i < 5; i++) begin : g_first_rank
    assign {w2_bit[i], w1_sum[i]} = fa(tree_vec[3*i], tree_vec[3*i+1], tree_vec[3*i+2]);
  end

  logic       w1_tmp;
  logic [1:0] w2_extra;
  logic       w2_tmp0;
  logic       w2_tmp1;
  logic [2:0] w4_bit;
  logic [3:0] count;

  assign {w2_extra[0], w1_tmp}   = fa(w1_sum[0], w1_sum[1], w1_sum[2]);
  assign {w2_extra[1], count[0]} = fa(w1_sum[3], w1_sum[4], w1_tmp);

  // Seven weight-2 bits reduce to one result bit plus three weight-4 carries.
  assign {w4_bit[0], w2_tmp0}  = fa(w2_bit[0], w2_bit[1], w2_bit[2]);
  assign {w4_bit[1], w2_tmp1}  = fa(w2_bit[3], w2_bit[4], w2_extra[0]);
  assign {w4_bit[2], count[1]} = fa(w2_tmp0, w2_tmp1, w2_extra[1]);

  assign {count[3], count[2]}  = fa(w4_bit[0], w4_bit[1], w4_bit[2]);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      cnt_q     <= count;
      out_valid <= tree_valid;
    end
  end

  assign {cnt3, cnt2, cnt1, cnt0} = cnt_q;

`ifdef ONES_COUNTER_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      none_set <= 1'b0;
      all_set  <= 1'b0;
    end else begin
      none_set <= (count == 4'd0);
      all_set  <= (count == 4'd15);
    end
  end
`endif

endmodule

// File: tb/tb_ones_counter_15.sv
// Scoreboard bench for ones_counter_15: one instance with the input register (latency 2), one without (latency 1).
// Flag outputs are checked too when ONES_COUNTER_FLAGS_EN is defined.
module tb_ones_counter_15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] in_vec = 15'h7FFF;
  logic        in_valid = 1'b1;

  logic r_c3, r_c2, r_c1, r_c0, r_valid;
  logic d_c3, d_c2, d_c1, d_c0, d_valid;
`ifdef ONES_COUNTER_FLAGS_EN
  logic r_none, r_all, d_none, d_all;
`endif

  int checks = 0;
  int passes = 0;

  // Entry layout: {all, none, valid, cnt[3:0]}
  logic [6:0] q_reg[$];
  logic [6:0] q_dir[$];

  always #10 clk = ~clk;

  ones_counter_15 #(.REG_INPUT(1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
    .cnt3(r_c3), .cnt2(r_c2), .cnt1(r_c1), .cnt0(r_c0), .out_valid(r_valid)
`ifdef ONES_COUNTER_FLAGS_EN
    , .none_set(r_none), .all_set(r_all)
`endif
  );

  ones_counter_15 #(.REG_INPUT(0)) dut_dir (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
    .cnt3(d_c3), .cnt2(d_c2), .cnt1(d_c1), .cnt0(d_c0), .out_valid(d_valid)
`ifdef ONES_COUNTER_FLAGS_EN
    , .none_set(d_none), .all_set(d_all)
`endif
  );

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s at %0t: got %b, expected %b", tag, $time, observed, expected);
  endtask

  // One clock step: compare due results at the negedge, then drive the next inputs and push their expectations.
  task automatic applyStimulus(input logic [14:0] vec, input logic valid, input logic rst);
    logic [6:0] e;
    logic [3:0] k;
    @(negedge clk);
    if (q_reg.size() == 2) begin
      e = q_reg.pop_front();
      checkOutput("reg_cnt", {r_c3, r_c2, r_c1, r_c0}, e[3:0]);
      checkOutput("reg_valid", {3'b0, r_valid}, {3'b0, e[4]});
`ifdef ONES_COUNTER_FLAGS_EN
      checkOutput("reg_flags", {2'b0, r_all, r_none}, {2'b0, e[6], e[5]});
`endif
    end
    if (q_dir.size() == 1) begin
      e = q_dir.pop_front();
      checkOutput("dir_cnt", {d_c3, d_c2, d_c1, d_c0}, e[3:0]);
      checkOutput("dir_valid", {3'b0, d_valid}, {3'b0, e[4]});
`ifdef ONES_COUNTER_FLAGS_EN
      checkOutput("dir_flags", {2'b0, d_all, d_none}, {2'b0, e[6], e[5]});
`endif
    end
    rst_n    = rst;
    in_vec   = vec;
    in_valid = valid;
    if (!rst) begin
      for (int i = 0; i < q_reg.size(); i++) q_reg[i] = 7'd0;
      for (int i = 0; i < q_dir.size(); i++) q_dir[i] = 7'd0;
      e = 7'd0;
    end else begin
      k = 4'($countones(vec));
      e = {k == 4'd15, k == 4'd0, valid, k};
    end
    q_reg.push_back(e);
    q_dir.push_back(e);
  endtask

  initial begin
    logic [14:0] therm;
    logic [14:0] pos_vecs[4];
    logic [14:0] b2b_vecs[5];
    pos_vecs = '{15'h4001, 15'h0421, 15'h5555, 15'h2AAA};
    b2b_vecs = '{15'h0000, 15'h7FFF, 15'h0001, 15'h00FF, 15'h0100};

    $display("[TB] reset with all-ones input");
    for (int i = 0; i < 3; i++) applyStimulus(15'h7FFF, 1'b1, 1'b0);
    applyStimulus(15'h7FFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(15'(($urandom)), 1'b0, 1'b1);

    $display("[TB] thermometer fill");
    therm = 15'h0;
    for (int i = 0; i < 10; i++) applyStimulus(therm, 1'b1, 1'b1);
    for (int b = 0; b < 15; b++) begin
      therm[b] = 1'b1;
      for (int i = 0; i < 10; i++) applyStimulus(therm, 1'b1, 1'b1);
    end

    $display("[TB] position independence");
    foreach (pos_vecs[i]) begin
      applyStimulus(pos_vecs[i], 1'b1, 1'b1);
      applyStimulus(pos_vecs[i], 1'b1, 1'b1);
    end

    $display("[TB] back-to-back vectors");
    foreach (b2b_vecs[i]) applyStimulus(b2b_vecs[i], 1'b1, 1'b1);

    $display("[TB] valid gaps");
    for (int i = 0; i < 10; i++) applyStimulus(15'($urandom), (i % 2) == 0, 1'b1);

    $display("[TB] reset mid-operation");
    applyStimulus(15'h7FFF, 1'b1, 1'b1);
    applyStimulus(15'h00F0, 1'b1, 1'b1);
    applyStimulus(15'h0F0F, 1'b1, 1'b0);
    applyStimulus(15'h0003, 1'b1, 1'b1);
    applyStimulus(15'h1234, 1'b0, 1'b1);

    $display("[TB] random vectors");
    for (int i = 0; i < 20; i++) applyStimulus(15'($urandom), 1'($urandom), 1'b1);

    for (int i = 0; i < 4; i++) applyStimulus(15'h0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
